// File: rtl/fpu_pkg.sv
// Shared FPU definitions: arbiter FSM state encoding and integer ALU opcodes.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/fpu_big_alu.sv
// Sign-magnitude integer add/subtract over WIDTH-bit magnitudes with a WIDTH+1-bit result.
// Combinational; a zero result is always reported with a positive sign.
module fpu_big_alu
    import fpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             a_sign_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_sign_i,
    output logic [WIDTH:0]   extended_result_o,
    output logic             result_sign_o
);

    logic b_sign_eff;

    always_comb begin
        b_sign_eff        = b_sign_i ^ (op_i == ALU_OP_SUB);
        extended_result_o = '0;
        result_sign_o     = 1'b0;
        if (a_sign_i == b_sign_eff) begin
            extended_result_o = {1'b0, a_i} + {1'b0, b_i};
            result_sign_o     = a_sign_i;
        end else if (a_i >= b_i) begin
            extended_result_o = {1'b0, a_i - b_i};
            result_sign_o     = a_sign_i;
        end else begin
            extended_result_o = {1'b0, b_i - a_i};
            result_sign_o     = b_sign_eff;
        end
        if (extended_result_o == '0) begin
            result_sign_o = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Round-robin selector: scans upward from last_i+1 (mod NREQ), returns one-hot and index.
// Purely combinational, no backpressure of its own.
module fpu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Offset NREQ lands back on last_i, so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_i) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_alu_arbiter.sv
// Shares one fpu_big_alu among NREQ requesters, round-robin, one op in flight.
// Grant to resp_valid is 2 cycles; resp_* hold until resp_ready, requests wait meanwhile.
module fpu_alu_arbiter
    import fpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ-1:0]       req_a_sign,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_b_sign,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH:0]        resp_result,
    output logic                  resp_sign,
    output logic                  busy
);

    state_t           state_q;
    logic [IDW-1:0]   last_grant_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic             a_sign_q;
    logic [WIDTH-1:0] b_q;
    logic             b_sign_q;
    logic [IDW-1:0]   id_q;
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH:0]   resp_result_q;
    logic             resp_sign_q;
    logic             busy_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   win_idx;
    logic             any_vld;

    logic             sel_op;
    logic [WIDTH-1:0] sel_a;
    logic             sel_a_sign;
    logic [WIDTH-1:0] sel_b;
    logic             sel_b_sign;

    logic [WIDTH:0]   alu_result;
    logic             alu_sign;

    fpu_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i  (req_valid),
        .last_i (last_grant_q),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (any_vld)
    );

    // The ALU only ever sees the operand registers, never the live request bus.
    fpu_big_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i              (op_q),
        .a_i               (a_q),
        .a_sign_i          (a_sign_q),
        .b_i               (b_q),
        .b_sign_i          (b_sign_q),
        .extended_result_o (alu_result),
        .result_sign_o     (alu_sign)
    );

    always_comb begin
        sel_op     = 1'b0;
        sel_a      = '0;
        sel_a_sign = 1'b0;
        sel_b      = '0;
        sel_b_sign = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_op     = req_op[i];
                sel_a      = req_a[i*WIDTH +: WIDTH];
                sel_a_sign = req_a_sign[i];
                sel_b      = req_b[i*WIDTH +: WIDTH];
                sel_b_sign = req_b_sign[i];
            end
        end
    end

    assign req_ready   = (rst_n && state_q == ST_IDLE) ? gnt : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_sign   = resp_sign_q;
    assign busy        = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= IDW'(NREQ - 1);
            op_q          <= 1'b0;
            a_q           <= '0;
            a_sign_q      <= 1'b0;
            b_q           <= '0;
            b_sign_q      <= 1'b0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_sign_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_vld) begin
                        op_q         <= sel_op;
                        a_q          <= sel_a;
                        a_sign_q     <= sel_a_sign;
                        b_q          <= sel_b;
                        b_sign_q     <= sel_b_sign;
                        id_q         <= win_idx;
                        last_grant_q <= win_idx;
                        state_q      <= ST_EXEC;
                        busy_q       <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    resp_result_q <= alu_result;
                    resp_sign_q   <= alu_sign;
                    resp_id_q     <= id_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_alu_arbiter.sv
// Bench for fpu_alu_arbiter: vector table, round-robin/FSM reference model and result scoreboard.
module tb_fpu_alu_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_a;
    logic [N-1:0]   req_a_sign;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_b_sign;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W:0]     resp_result;
    logic           resp_sign;
    logic           busy;

    always #5 clk = ~clk;

    fpu_alu_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_a_sign  (req_a_sign),
        .req_b       (req_b),
        .req_b_sign  (req_b_sign),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_sign   (resp_sign),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Signed-integer reference: {sign, magnitude}, zero is positive.
    function automatic logic [65:0] model(input logic op, input logic [63:0] a, input logic as,
                                          input logic [63:0] b, input logic bs);
        logic signed [67:0] va, vb, r;
        va = $signed({4'b0, a});
        if (as) va = -va;
        vb = $signed({4'b0, b});
        if (bs) vb = -vb;
        r = op ? (va - vb) : (va + vb);
        if (r < 0) begin
            r = -r;
            return {1'b1, r[64:0]};
        end
        return {1'b0, r[64:0]};
    endfunction

    typedef struct {
        int          id;
        logic        op;
        logic [63:0] a;
        logic        as;
        logic [63:0] b;
        logic        bs;
        logic [64:0] er;
        logic        es;
    } vec_t;

    typedef struct {
        int          id;
        logic [64:0] res;
        logic        sign;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    int   glog[$];
    int   gcyc[$];
    int   cyc       = 0;
    int   mstate    = 0;
    int   exp_last  = N - 1;
    bit   rst_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference FSM/arbiter; pushes expected results at each grant, compares while in RESP.
    always @(negedge clk) begin : mon
        int          win;
        logic [N-1:0] oh;
        logic [65:0] m;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            if (rst_prev) begin
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_id", resp_id, 0);
                chk("rst_resp_result", resp_result, 0);
                chk("rst_resp_sign", resp_sign, 0);
                chk("rst_busy", busy, 0);
            end
            sb.delete();
            mstate   = 0;
            exp_last = N - 1;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            chk("busy", busy, (mstate != 0));
            if (mstate == 0) begin
                win = -1;
                oh  = '0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (exp_last + k) % N;
                    if (win < 0 && req_valid[c]) win = c;
                end
                if (win >= 0) oh[win] = 1'b1;
                chk("grant", req_ready, oh);
                chk("resp_valid_idle", resp_valid, 0);
                if (win >= 0) begin
                    m = model(req_op[win], req_a[win*W +: W], req_a_sign[win],
                              req_b[win*W +: W], req_b_sign[win]);
                    e.id   = win;
                    e.res  = m[64:0];
                    e.sign = m[65];
                    sb.push_back(e);
                    glog.push_back(win);
                    gcyc.push_back(cyc);
                    exp_last = win;
                    mstate   = 1;
                end
            end else if (mstate == 1) begin
                chk("req_ready_exec", req_ready, 0);
                chk("resp_valid_exec", resp_valid, 0);
                mstate = 2;
            end else begin
                chk("req_ready_resp", req_ready, 0);
                chk("resp_valid_resp", resp_valid, 1);
                if (sb.size() > 0) begin
                    chk("sb_id", resp_id, sb[0].id);
                    chk("sb_result", resp_result, sb[0].res);
                    chk("sb_sign", resp_sign, sb[0].sign);
                end
                if (resp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    mstate = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [63:0] a, input logic as,
                           input logic [63:0] b, input logic bs);
        req_op[i]          = op;
        req_a[i*W +: W]    = a;
        req_a_sign[i]      = as;
        req_b[i*W +: W]    = b;
        req_b_sign[i]      = bs;
    endtask

    task automatic wait_grant(input int i, output int gc);
        bit got;
        got = 1'b0;
        gc  = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        gc = cyc;
        chk("grant_wait", got, 1);
    endtask

    task automatic wait_resp(output int rc);
        bit got;
        got = 1'b0;
        rc  = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = resp_valid;
        end
        rc = cyc;
        chk("resp_wait", got, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int gc, rc, hs;

        vt[0] = '{2, 1'b0, 64'd5, 1'b0, 64'd3, 1'b0, 65'd8, 1'b0};
        vt[1] = '{1, 1'b1, 64'd3, 1'b0, 64'd5, 1'b0, 65'd2, 1'b1};
        vt[2] = '{3, 1'b0, 64'd7, 1'b1, 64'd2, 1'b0, 65'd5, 1'b1};
        vt[3] = '{0, 1'b1, 64'd4, 1'b1, 64'd6, 1'b1, 65'd2, 1'b0};
        vt[4] = '{2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                  65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0};
        vt[5] = '{1, 1'b1, 64'd5, 1'b1, 64'd5, 1'b1, 65'd0, 1'b0};
        vt[6] = '{0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd1, 1'b0,
                  65'h1_0000_0000_0000_0000, 1'b1};
        vt[7] = '{3, 1'b0, 64'd1, 1'b0, 64'd10, 1'b1, 65'd9, 1'b1};

        // Reset with every requester asking
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '1;
        req_op     = '0;
        req_a      = '0;
        req_a_sign = '0;
        req_b      = '0;
        req_b_sign = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 64'(i + 1), 1'b0, 64'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp(rc);
        chk("first_id", resp_id, 0);
        chk("first_result", resp_result, 11);
        tick();

        // Table of single-requester operations
        for (int v = 0; v < 8; v++) begin
            set_req(vt[v].id, vt[v].op, vt[v].a, vt[v].as, vt[v].b, vt[v].bs);
            req_valid[vt[v].id] = 1'b1;
            wait_grant(vt[v].id, gc);
            tick();
            req_valid = '0;
            wait_resp(rc);
            chk("vec_latency", rc - gc, 2);
            chk("vec_id", resp_id, vt[v].id);
            chk("vec_result", resp_result, vt[v].er);
            chk("vec_sign", resp_sign, vt[v].es);
            tick();
        end

        // All requesters contending
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < N; i++)
            set_req(i, (i % 2) == 1, 64'(100 * (i + 1)), (i / 2) == 1, 64'(37 * i + 5), (i % 2) == 1);
        req_valid = '1;
        for (int n = 0; n < 100 && glog.size() < 8; n++) @(negedge clk);
        tick();
        req_valid = '0;
        chk("fair_count", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) begin
            chk("fair_order", glog[k], k % 4);
            if (k > 0) chk("fair_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        repeat (4) tick();

        // Backpressure in RESP
        resp_ready = 1'b0;
        set_req(2, 1'b1, 64'd9, 1'b0, 64'd4, 1'b0);
        req_valid[2] = 1'b1;
        wait_grant(2, gc);
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 64'd20, 1'b0, 64'd22, 1'b1);
        req_valid[0] = 1'b1;
        wait_resp(rc);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_id", resp_id, 2);
            chk("bp_result", resp_result, 5);
            chk("bp_sign", resp_sign, 0);
            chk("bp_req_ready", req_ready, 0);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0001);
        chk("bp_next_gap", cyc - hs, 1);
        tick();
        req_valid = '0;
        wait_resp(rc);
        chk("bp2_id", resp_id, 0);
        chk("bp2_result", resp_result, 2);
        chk("bp2_sign", resp_sign, 1);
        tick();

        // Reset while an operation is in EXEC
        set_req(3, 1'b0, 64'd1, 1'b0, 64'd1, 1'b0);
        set_req(0, 1'b0, 64'd50, 1'b0, 64'd7, 1'b0);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mr_grant", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_regrant", req_ready, 4'b0001);
        chk("mr_no_resp", resp_valid, 0);
        chk("mr_busy", busy, 0);
        tick();
        req_valid = '0;
        wait_resp(rc);
        chk("mr_id", resp_id, 0);
        chk("mr_result", resp_result, 57);
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
